pio_out_ctrl: RTL

PIO_OUT_CTRL -- requirements
Module: pio_out_ctrl

---
 rtl/pio_out_pkg.sv | 16 +
 rtl/pio_blink_prescaler.sv | 43 ++++
 rtl/pio_out_ctrl.sv | 108 ++++++++++
 3 files changed

// File: rtl/pio_out_pkg.sv
// pio_out_pkg -- shared constants for the PIO output controller.
//   Register word offsets on the 3-bit Avalon-MM address bus and the
//   default width of the blink prescaler.
package pio_out_pkg;

  localparam logic [2:0] OFF_DATA     = 3'd0;
  localparam logic [2:0] OFF_SET      = 3'd1;
  localparam logic [2:0] OFF_CLR      = 3'd2;
  localparam logic [2:0] OFF_TOGGLE   = 3'd3;
  localparam logic [2:0] OFF_MASK     = 3'd4;
  localparam logic [2:0] OFF_PERIOD   = 3'd5;
  localparam logic [2:0] OFF_STATUS   = 3'd6;

  localparam int PERIOD_W_DEFAULT = 24;

endpackage

// File: rtl/pio_blink_prescaler.sv
// pio_blink_prescaler -- down-counting prescaler that produces the blink phase.
//   Ports:
//     clk, reset_n  : clock, asynchronous active-low reset
//     period        : current half-period length in clk cycles (0 = stopped)
//     load          : a new period is being written this cycle
//     load_value    : the period value being written
//     phase         : blink phase, inverts every 'period' cycles
module pio_blink_prescaler
  import pio_out_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PERIOD_W-1:0] period,
  input  logic                load,
  input  logic [PERIOD_W-1:0] load_value,
  output logic                phase
);

  logic [PERIOD_W-1:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      phase <= 1'b0;
    end else if (load) begin
      // A fresh period restarts the half-cycle in the low phase and wins
      // over any terminal count reached on the same edge.
      count <= (load_value == '0) ? '0 : load_value - PERIOD_W'(1);
      phase <= 1'b0;
    end else if (period == '0) begin
      count <= '0;
      phase <= 1'b0;
    end else if (count == '0) begin
      count <= period - PERIOD_W'(1);
      phase <= ~phase;
    end else begin
      count <= count - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/pio_out_ctrl.sv
// pio_out_ctrl -- Avalon-MM controlled parallel output port with optional blink.
//   Build option: define PIO_OUT_CTRL_BLINK_EN to include BLINK_MASK,
//   BLINK_PERIOD, STATUS and the blink prescaler. Without it offsets 4-6
//   read 0, ignore writes, and out_port is simply the registered DATA.
//   Ports:
//     clk, reset_n          : clock, asynchronous active-low reset
//     address               : word register select (0..7)
//     chipselect, write_n   : write when chipselect=1 and write_n=0
//     writedata             : write data (bits above WIDTH/PERIOD_W ignored)
//     readdata              : combinational read data, zero-extended
//     out_port              : registered channel outputs
module pio_out_ctrl
  import pio_out_pkg::*;
#(
  parameter int               WIDTH       = 10,
  parameter logic [WIDTH-1:0] RESET_VALUE = 10'h255,
  parameter int               PERIOD_W    = PERIOD_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] drive;
  logic             unused_in;

  assign wr = chipselect & ~write_n;
  assign wd = writedata[WIDTH-1:0];

  // Upper write-data bits are intentionally dropped.
  assign unused_in = ^{writedata, 1'(PERIOD_W)};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        OFF_DATA:   data <= wd;
        OFF_SET:    data <= data | wd;
        OFF_CLR:    data <= data & ~wd;
        OFF_TOGGLE: data <= data ^ wd;
        default:    ;
      endcase
    end
  end

`ifdef PIO_OUT_CTRL_BLINK_EN
  logic [WIDTH-1:0]    mask;
  logic [PERIOD_W-1:0] period;
  logic                period_we;
  logic                phase;

  assign period_we = wr && (address == OFF_PERIOD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      period <= '0;
    end else if (wr) begin
      if (address == OFF_MASK)   mask   <= wd;
      if (address == OFF_PERIOD) period <= writedata[PERIOD_W-1:0];
    end
  end

  pio_blink_prescaler #(
    .PERIOD_W (PERIOD_W)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .period     (period),
    .load       (period_we),
    .load_value (writedata[PERIOD_W-1:0]),
    .phase      (phase)
  );

  assign drive = data ^ (mask & {WIDTH{phase}});
`else
  assign drive = data;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      OFF_DATA:   readdata = 32'(data);
`ifdef PIO_OUT_CTRL_BLINK_EN
      OFF_MASK:   readdata = 32'(mask);
      OFF_PERIOD: readdata = 32'(period);
      OFF_STATUS: readdata = {30'b0, period != '0, phase};
`endif
      default:    readdata = '0;
    endcase
  end

  // Output stage: one register between the control registers and the pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_port <= RESET_VALUE;
    else          out_port <= drive;
  end

endmodule
